// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: serves whole-line cache fills/writebacks as BEATS-beat memory bursts.
// Latency: request sampled at edge T, burst strobe cycles T+1..T+BEATS (no stalls), resp_o at T+BEATS+1.
// Backpressure: resp_i=0 stalls the burst; counter, buffer, burst_o and address_o hold.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   address_i/read_i/write_i      cache line request (level, held until resp_o)
//   line_i / line_o               writeback data in / fill data out (line_o holds until next read done)
//   resp_o                        one-cycle completion pulse
//   address_o/read_o/write_o      memory burst address and strobes (registered)
//   burst_o / burst_i             write beat data out / read beat data in
//   resp_i                        memory beat accept/valid, one beat per cycle
//   err_o                         sticky protocol error flag, present only with
//                                 CACHELINE_ADAPTOR_PROTO_CHK_EN defined
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
  ,
  output logic               err_o
`endif
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [LINE_W-1:0]   r_buf, w_buf_nxt;
  logic [31-OFF:0]     r_addr, w_addr_nxt;
  logic [LINE_W-1:0]   r_line;
  logic                r_resp, r_read, r_write;
  logic [BURST_W-1:0]  r_burst;

  // Byte offset within the line is irrelevant: bursts are always line aligned.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^address_i[OFF-1:0];

  assign w_cnt_inc = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      S_IDLE: begin
        // Write wins when both are raised; the still-held read is launched
        // from IDLE once the write has completed.
        if (write_i) begin
          w_state_nxt = S_WR;
          w_buf_nxt   = line_i;
          w_cnt_nxt   = '0;
          w_addr_nxt  = address_i[31:OFF];
        end else if (read_i) begin
          w_state_nxt = S_RD;
          w_cnt_nxt   = '0;
          w_addr_nxt  = address_i[31:OFF];
        end
      end
      S_RD: begin
        if (resp_i) begin
          w_buf_nxt[r_cnt*BURST_W +: BURST_W] = burst_i;
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == LAST) w_state_nxt = S_DONE;
        end
      end
      S_WR: begin
        if (resp_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_resp  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_addr  <= w_addr_nxt;
      r_resp  <= (w_state_nxt == S_DONE);
      r_read  <= (w_state_nxt == S_RD);
      r_write <= (w_state_nxt == S_WR);
      r_burst <= (w_state_nxt == S_WR) ? w_buf_nxt[w_cnt_nxt*BURST_W +: BURST_W] : '0;
      if (r_state == S_RD && w_state_nxt == S_DONE) r_line <= w_buf_nxt;
    end
  end

  assign line_o    = r_line;
  assign resp_o    = r_resp;
  assign address_o = {r_addr, {OFF{1'b0}}};
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign burst_o   = r_burst;

`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
  // Sticky: a beat offered while no burst is active, or the cache abandoning
  // its request mid-burst. Observation only, never steers the data path.
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (((r_state == S_IDLE || r_state == S_DONE) && resp_i) ||
                 ((r_state == S_RD || r_state == S_WR) && !read_i && !write_i)) begin
      r_err <= 1'b1;
    end
  end
  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        address_i;
  logic               read_i, write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [31:0]        address_o;
  logic               read_o, write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
  logic               err_o;
`endif

  int checks = 0;
  int errors = 0;
  int g_pre = 0;                 // idle cycles expected before the next launch
  logic [LINE_W-1:0] last_rd_line = '0;
  bit g_err_exp = 1'b0;

  cacheline_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i),
    .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete line transfer as seen by cache and memory. 'line' is the
  // writeback data (write) or the data memory returns (read). plen>0 takes
  // resp_i from pat bit by bit, otherwise resp_i is random with stall_pct.
  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input int stall_pct, input logic [31:0] pat, input int plen, input string name);
    logic [31:0] exp_addr;
    int k;
    int cyc;
    exp_addr = addr & 32'hFFFF_FFE0;
    address_i = addr;
    resp_i = 1'b0;
    if (is_wr) begin
      line_i = line;
      write_i = 1'b1;
    end else begin
      read_i = 1'b1;
    end
    repeat (g_pre) begin
      @(negedge clk);
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0)
        begin errors++; $display("FAIL %s pre-launch idle: rd=%b wr=%b resp=%b required 0 0 0", name, read_o, write_o, resp_o); end
    end
    k = 0;
    cyc = 0;
    while (k < BEATS && cyc < 200) begin
      @(negedge clk);
      if (cyc == 1 && is_wr) line_i = rand_line();   // data must already be captured
      checks++;
      if ((is_wr ? write_o : read_o) !== 1'b1 || (is_wr ? read_o : write_o) !== 1'b0 || resp_o !== 1'b0)
        begin errors++; $display("FAIL %s strobe beat %0d: rd=%b wr=%b resp=%b required is_wr=%b", name, k, read_o, write_o, resp_o, is_wr); end
      checks++;
      if (address_o !== exp_addr)
        begin errors++; $display("FAIL %s address_o: got %h required %h", name, address_o, exp_addr); end
      if (is_wr) begin
        checks++;
        if (burst_o !== line[k*BURST_W +: BURST_W])
          begin errors++; $display("FAIL %s burst_o beat %0d: got %h required %h", name, k, burst_o, line[k*BURST_W +: BURST_W]); end
      end
      if (plen > 0) resp_i = (cyc < plen) ? pat[cyc] : 1'b1;
      else          resp_i = ($urandom_range(99) >= stall_pct);
      burst_i = {$urandom, $urandom};
      if (resp_i && !is_wr) burst_i = line[k*BURST_W +: BURST_W];
      if (resp_i) k++;
      cyc++;
    end
    if (k < BEATS) begin
      errors++;
      $display("FAIL %s timeout: beats %0d required %0d", name, k, BEATS);
    end
    @(negedge clk);
    resp_i = 1'b0;
    burst_i = {$urandom, $urandom};
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0)
      begin errors++; $display("FAIL %s completion: resp=%b rd=%b wr=%b required 1 0 0", name, resp_o, read_o, write_o); end
    if (!is_wr) last_rd_line = line;
    checks++;
    if (line_o !== last_rd_line)
      begin errors++; $display("FAIL %s line_o: got %h required %h", name, line_o, last_rd_line); end
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
    checks++;
    if (err_o !== g_err_exp)
      begin errors++; $display("FAIL %s err_o: got %b required %b", name, err_o, g_err_exp); end
`endif
    if (is_wr) write_i = 1'b0;
    else       read_i = 1'b0;
    g_pre = 1;
  endtask

  task automatic idle_check(input int n, input string name);
    repeat (n) begin
      @(negedge clk);
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0)
        begin errors++; $display("FAIL %s idle: rd=%b wr=%b resp=%b required 0 0 0", name, read_o, write_o, resp_o); end
    end
    g_pre = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    last_rd_line = '0;
    g_err_exp = 1'b0;
    g_pre = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || address_o !== 32'h0 || burst_o !== '0 || line_o !== '0)
      begin errors++; $display("FAIL reset outputs: rd=%b wr=%b resp=%b addr=%h burst=%h line=%h required all 0", read_o, write_o, resp_o, address_o, burst_o, line_o); end
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset err_o: got %b required 0", err_o); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    logic [LINE_W-1:0] l;
    l = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    run_txn(1'b0, 32'h0000_1234, l, 0, 32'h0, 0, "read_basic");
    idle_check(1, "read_basic_after");
  endtask

  task automatic test_write_stall();
    logic [LINE_W-1:0] l;
    l = 256'h0123456789ABCDEF_FEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
    run_txn(1'b1, 32'h0000_8000, l, 0, 32'b111001, 6, "write_stall");
    idle_check(1, "write_stall_after");
  endtask

  task automatic test_both();
    logic [LINE_W-1:0] wl, rl;
    wl = rand_line();
    rl = rand_line();
    read_i = 1'b1;
    run_txn(1'b1, 32'h0000_2040, wl, 20, 32'h0, 0, "both_write");
    run_txn(1'b0, 32'h0000_2040, rl, 20, 32'h0, 0, "both_read");
    idle_check(4, "both_no_third");
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] l;
    address_i = 32'h0000_3000;
    read_i = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || write_o !== 1'b0 || line_o !== '0)
      begin errors++; $display("FAIL reset_mid: rd=%b wr=%b resp=%b line=%h required all 0", read_o, write_o, resp_o, line_o); end
    rst = 1'b0;
    last_rd_line = '0;
    g_err_exp = 1'b0;
    g_pre = 0;
    l = rand_line();
    run_txn(1'b0, 32'h0000_3020, l, 0, 32'h0, 0, "reset_mid_reread");
    idle_check(1, "reset_mid_after");
  endtask

  task automatic test_stray_resp();
    resp_i = 1'b1;
    idle_check(3, "stray_resp");
`ifdef CACHELINE_ADAPTOR_PROTO_CHK_EN
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL stray err_o set: got %b required 1", err_o); end
`endif
    g_err_exp = 1'b1;
    resp_i = 1'b0;
    run_txn(1'b0, 32'h0000_5000, rand_line(), 0, 32'h0, 0, "stray_then_read");
    idle_check(1, "stray_after");
    test_reset();
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 32'h0000_0040, rand_line(), 0, 32'h0, 0, "b2b_0x40");
    run_txn(1'b0, 32'h0000_0060, rand_line(), 0, 32'h0, 0, "b2b_0x60");
    idle_check(4, "b2b_no_dup");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      run_txn($urandom_range(1), $urandom, rand_line(), 35, 32'h0, 0, "random");
      if ($urandom_range(3) == 0) idle_check($urandom_range(3, 1), "random_idle");
    end
    idle_check(2, "random_end");
  endtask

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    test_reset();
    test_read_basic();
    test_write_stall();
    test_both();
    test_reset_mid();
    test_stray_resp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
